// File: rtl/seq_detect_n.sv
// ---------------------------------------------------------------------------
// seq_detect_n
//   Parametrised serial pattern detector. One bit of x_i is shifted into a
//   history register on every enabled clock. Once PLEN valid bits have been
//   collected, the newest PLEN bits are compared against the run-time
//   pattern_i. Each match gives a registered one-cycle pulse on z_o and
//   advances a saturating match counter.
//
// Parameters
//   PLEN         pattern length in bits, legal 2..16
//   CNTW         match counter width, legal 1..16
//
// Ports
//   clk_i        clock, rising-edge active
//   rst_ni       asynchronous active-low reset
//   en_i         sample enable; x_i is consumed only when en_i=1
//   x_i          serial data bit
//   pattern_i    pattern to detect, MSB = earliest bit; used live, not latched
//   overlap_i    1: matches may share bits; 0: history dropped after a match
//   clr_i        synchronous clear of history, state, z_o and counter
//   z_o          registered one-cycle match pulse
//   match_cnt_o  matches since reset/clear, saturating at all-ones
//   cnt_sat_o    high while match_cnt_o is all-ones
// ---------------------------------------------------------------------------
module seq_detect_n #(
    parameter int PLEN = 2,
    parameter int CNTW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            x_i,
    input  logic [PLEN-1:0] pattern_i,
    input  logic            overlap_i,
    input  logic            clr_i,
    output logic            z_o,
    output logic [CNTW-1:0] match_cnt_o,
    output logic            cnt_sat_o
);

    localparam int            FW     = $clog2(PLEN + 1);
    localparam logic [FW-1:0] PLEN_F = FW'(PLEN);

    // EMPTY: no valid bits, FILL: partially filled, ARMED: full window.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t          state_q;
    logic [PLEN-1:0] hist_q, hist_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [CNTW-1:0] match_cnt_q;
    logic            z_q;
    logic            match;

    // Candidate history/fill if the current bit is consumed, and whether that
    // completes a match against the pattern presented on this edge.
    // NOTE: every signal assigned in a combinational block gets a value on all
    // paths (here unconditionally), otherwise a latch is inferred.
    always_comb begin
        hist_d = {hist_q[PLEN-2:0], x_i};
        fill_d = (state_q == ARMED) ? PLEN_F : fill_q + FW'(1);
        match  = (fill_d == PLEN_F) && (hist_d == pattern_i);
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            hist_q      <= '0;
            fill_q      <= '0;
            z_q         <= 1'b0;
            match_cnt_q <= '0;
        end else if (clr_i) begin
            // Clear wins over a coincident sample, including a completing bit.
            state_q     <= EMPTY;
            hist_q      <= '0;
            fill_q      <= '0;
            z_q         <= 1'b0;
            match_cnt_q <= '0;
        end else if (en_i) begin
            z_q <= match;
            if (match && !overlap_i) begin
                // Non-overlapping: a fresh PLEN bits are needed for the next hit.
                state_q <= EMPTY;
                hist_q  <= '0;
                fill_q  <= '0;
            end else begin
                state_q <= (fill_d == PLEN_F) ? ARMED : FILL;
                hist_q  <= hist_d;
                fill_q  <= fill_d;
            end
            if (match && !(&match_cnt_q)) begin
                match_cnt_q <= match_cnt_q + CNTW'(1);
            end
        end else begin
            z_q <= 1'b0;
        end
    end

    assign z_o         = z_q;
    assign match_cnt_o = match_cnt_q;
    assign cnt_sat_o   = &match_cnt_q;

endmodule

// File: tb/tb_seq_detect_n.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_n
//   Two detector instances: A (PLEN=2, CNTW=2) and B (PLEN=4, CNTW=8).
//   A reference model keeps the list of bits consumed since the last
//   reset/clear/non-overlap match and declares a match when its newest PLEN
//   bits spell the pattern.
// ---------------------------------------------------------------------------
module tb_seq_detect_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, x_a, ovl_a, clr_a;
    logic [1:0] pat_a;
    logic       z_a, sat_a;
    logic [1:0] cnt_a_o;
    logic       en_b, x_b, ovl_b, clr_b;
    logic [3:0] pat_b;
    logic       z_b, sat_b;
    logic [7:0] cnt_b_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit hq_a[$];
    bit hq_b[$];
    int cnt_a, cnt_b;
    bit ez_a, ez_b;

    always #5 clk = ~clk;

    seq_detect_n #(.PLEN(2), .CNTW(2)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .x_i(x_a),
        .pattern_i(pat_a), .overlap_i(ovl_a), .clr_i(clr_a),
        .z_o(z_a), .match_cnt_o(cnt_a_o), .cnt_sat_o(sat_a)
    );

    seq_detect_n #(.PLEN(4), .CNTW(8)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .x_i(x_b),
        .pattern_i(pat_b), .overlap_i(ovl_b), .clr_i(clr_b),
        .z_o(z_b), .match_cnt_o(cnt_b_o), .cnt_sat_o(sat_b)
    );

    function automatic bit tail_match(input bit q[$], input int plen, input logic [15:0] pat);
        if (q.size() < plen) return 1'b0;
        for (int i = 0; i < plen; i++) begin
            if (q[q.size() - plen + i] != pat[plen-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit ok_a();
        return (z_a === ez_a) && (cnt_a_o === 2'(cnt_a)) && (sat_a === (cnt_a == 3));
    endfunction

    function automatic bit ok_b();
        return (z_b === ez_b) && (cnt_b_o === 8'(cnt_b)) && (sat_b === (cnt_b == 255));
    endfunction

    function automatic void model_reset();
        hq_a.delete(); hq_b.delete();
        cnt_a = 0; cnt_b = 0; ez_a = 0; ez_b = 0;
    endfunction

    // One rising edge; both models advance from the inputs seen at that edge,
    // then outputs settle for sampling 1 time unit later.
    task automatic tick();
        bit m;
        @(posedge clk);
        ez_a = 1'b0;
        if (clr_a) begin
            hq_a.delete(); cnt_a = 0;
        end else if (en_a) begin
            hq_a.push_back(x_a);
            if (hq_a.size() > 16) void'(hq_a.pop_front());
            m = tail_match(hq_a, 2, 16'(pat_a));
            ez_a = m;
            if (m) begin
                if (cnt_a < 3) cnt_a++;
                if (!ovl_a) hq_a.delete();
            end
        end
        ez_b = 1'b0;
        if (clr_b) begin
            hq_b.delete(); cnt_b = 0;
        end else if (en_b) begin
            hq_b.push_back(x_b);
            if (hq_b.size() > 16) void'(hq_b.pop_front());
            m = tail_match(hq_b, 4, 16'(pat_b));
            ez_b = m;
            if (m) begin
                if (cnt_b < 255) cnt_b++;
                if (!ovl_b) hq_b.delete();
            end
        end
        #1;
    endtask

    task automatic drive_a(input bit en, input bit x, input bit clr);
        en_a = en; x_a = x; clr_a = clr;
        tick();
    endtask

    task automatic drive_b(input bit en, input bit x, input bit clr);
        en_b = en; x_b = x; clr_b = clr;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {en_a, x_a, ovl_a, clr_a, en_b, x_b, ovl_b, clr_b} = '0;
        pat_a = 2'b01; pat_b = 4'b1010;
        model_reset();
        #2;
        n_checks++;
        if (z_a !== 1'b0 || cnt_a_o !== 2'd0 || sat_a !== 1'b0 ||
            z_b !== 1'b0 || cnt_b_o !== 8'd0 || sat_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: a z=%b cnt=%0d sat=%b b z=%b cnt=%0d sat=%b, want all 0",
                     z_a, cnt_a_o, sat_a, z_b, cnt_b_o, sat_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_plen2_overlap();
        bit seq [14] = '{0,0,1,0,0,0,1,1,1,0,1,1,0,0};
        bit want_z;
        pat_a = 2'b01; ovl_a = 1'b1;
        drive_a(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            drive_a(1'b1, seq[i], 1'b0);
            want_z = (i == 2) || (i == 6) || (i == 10);
            n_checks++;
            if (!ok_a() || z_a !== want_z) begin
                n_fail++;
                $display("FAIL plen2_overlap[%0d]: z=%b cnt=%0d sat=%b, want z=%b cnt=%0d",
                         i, z_a, cnt_a_o, sat_a, want_z, cnt_a);
            end
        end
        n_checks++;
        if (cnt_a_o !== 2'd3) begin
            n_fail++;
            $display("FAIL plen2_count: cnt=%0d, want 3", cnt_a_o);
        end
    endtask

    task automatic test_plen4_modes();
        bit seq [6] = '{1,0,1,0,1,0};
        bit want_z;
        pat_b = 4'b1010;
        for (int mode = 1; mode >= 0; mode--) begin
            ovl_b = 1'(mode);
            drive_b(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 6; i++) begin
                drive_b(1'b1, seq[i], 1'b0);
                want_z = (i == 3) || (mode == 1 && i == 5);
                n_checks++;
                if (!ok_b() || z_b !== want_z) begin
                    n_fail++;
                    $display("FAIL plen4_ovl%0d[%0d]: z=%b cnt=%0d, want z=%b cnt=%0d",
                             mode, i, z_b, cnt_b_o, want_z, cnt_b);
                end
            end
            n_checks++;
            if (cnt_b_o !== 8'((mode == 1) ? 2 : 1)) begin
                n_fail++;
                $display("FAIL plen4_count_ovl%0d: cnt=%0d, want %0d",
                         mode, cnt_b_o, (mode == 1) ? 2 : 1);
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_enable_gap();
        pat_a = 2'b01; ovl_a = 1'b1;
        drive_a(1'b0, 1'b0, 1'b1);
        drive_a(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (z_a !== 1'b0 || !ok_a()) begin
                n_fail++;
                $display("FAIL gap_idle[%0d]: z=%b cnt=%0d, want z=0 cnt=0", i, z_a, cnt_a_o);
            end
        end
        drive_a(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (z_a !== 1'b1 || !ok_a()) begin
            n_fail++;
            $display("FAIL gap_match: z=%b cnt=%0d, want z=1 cnt=1", z_a, cnt_a_o);
        end
        drive_a(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (z_a !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_pulse_width: z=%b, want 0", z_a);
        end
    endtask

    task automatic test_saturate();
        int want_cnt [5] = '{1, 2, 3, 3, 3};
        pat_a = 2'b01; ovl_a = 1'b1;
        drive_a(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive_a(1'b1, 1'b0, 1'b0);
            drive_a(1'b1, 1'b1, 1'b0);
            n_checks++;
            if (!ok_a() || cnt_a_o !== 2'(want_cnt[k]) || sat_a !== (k >= 2)) begin
                n_fail++;
                $display("FAIL saturate[%0d]: cnt=%0d sat=%b z=%b, want cnt=%0d sat=%b z=1",
                         k, cnt_a_o, sat_a, z_a, want_cnt[k], k >= 2);
            end
        end
        drive_a(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (cnt_a_o !== 2'd0 || sat_a !== 1'b0 || z_a !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate_clr: cnt=%0d sat=%b z=%b, want 0 0 0", cnt_a_o, sat_a, z_a);
        end
    endtask

    task automatic test_clr_same_edge();
        pat_a = 2'b01; ovl_a = 1'b1;
        drive_a(1'b1, 1'b0, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (z_a !== 1'b0 || cnt_a_o !== 2'd0 || !ok_a()) begin
            n_fail++;
            $display("FAIL clr_edge: z=%b cnt=%0d, want z=0 cnt=0", z_a, cnt_a_o);
        end
        // History was discarded, so a lone 1 cannot complete "01".
        drive_a(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (z_a !== 1'b0 || !ok_a()) begin
            n_fail++;
            $display("FAIL clr_history: z=%b, want 0", z_a);
        end
    endtask

    task automatic test_reset_mid();
        pat_a = 2'b01; ovl_a = 1'b1;
        drive_a(1'b0, 1'b0, 1'b1);
        drive_a(1'b1, 1'b0, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (z_a !== 1'b0 || cnt_a_o !== 2'd0 || sat_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: z=%b cnt=%0d sat=%b, want 0 0 0", z_a, cnt_a_o, sat_a);
        end
        #2 rst_n = 1'b1;
        drive_a(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (z_a !== 1'b0 || !ok_a()) begin
            n_fail++;
            $display("FAIL reset_mid_lone1: z=%b, want 0", z_a);
        end
        drive_a(1'b1, 1'b0, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (z_a !== 1'b1 || cnt_a_o !== 2'd1 || !ok_a()) begin
            n_fail++;
            $display("FAIL reset_mid_rematch: z=%b cnt=%0d, want z=1 cnt=1", z_a, cnt_a_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            en_a  = ($urandom_range(0, 3) != 0);
            x_a   = 1'($urandom);
            clr_a = ($urandom_range(0, 40) == 0);
            en_b  = ($urandom_range(0, 3) != 0);
            x_b   = 1'($urandom);
            clr_b = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 30) == 0) ovl_a = ~ovl_a;
            if ($urandom_range(0, 30) == 0) ovl_b = ~ovl_b;
            if ($urandom_range(0, 25) == 0) pat_a = 2'($urandom);
            if ($urandom_range(0, 25) == 0) pat_b = 4'($urandom);
            tick();
            n_checks++;
            if (!ok_a()) begin
                n_fail++;
                $display("FAIL random_a[%0d]: z=%b cnt=%0d sat=%b, want z=%b cnt=%0d",
                         i, z_a, cnt_a_o, sat_a, ez_a, cnt_a);
            end
            n_checks++;
            if (!ok_b()) begin
                n_fail++;
                $display("FAIL random_b[%0d]: z=%b cnt=%0d sat=%b, want z=%b cnt=%0d",
                         i, z_b, cnt_b_o, sat_b, ez_b, cnt_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plen2_overlap();
        test_plen4_modes();
        test_enable_gap();
        test_saturate();
        test_clr_same_edge();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
